bin_bcd_seq: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter (iterative double-dabble).

---
 rtl/bin_bcd_seq.sv | 181 ++++++++++++++++++
 tb/tb_bin_bcd_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_bcd_seq
//
// Sequential binary-to-BCD converter using the iterative double-dabble
// (shift-and-add-3) algorithm. One binary bit is consumed per clock.
// The result is registered and held until the next conversion completes.
// Sits in the frequency-counter display path: the count register feeds it
// and the digit drivers consume its packed BCD output.
//
// Parameters
//   BIN_W   binary operand width (>= 1)
//   DIGITS  number of BCD digits produced (bcd is 4*DIGITS bits)
//
// Ports
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          asynchronous active-low reset
//   start     in   1          conversion request, honoured only while idle
//   bin       in   BIN_W      binary operand, captured on the accepting edge
//   busy      out  1          high while a conversion is in progress
//   done      out  1          one-cycle pulse when bcd/overflow are updated
//   bcd       out  4*DIGITS   packed BCD result, digit 0 (ones) in bits [3:0]
//   overflow  out  1          value did not fit in DIGITS digits
//
// Timing: start sampled at edge E0, BIN_W shift iterations follow, then one
// DONE cycle; done is visible in the cycle after edge E0+BIN_W+1. In the
// done cycle the FSM is already idle, so a new start there is accepted.
// ----------------------------------------------------------------------------
module bin_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Double-dabble adjust: every digit >= 5 gets +3 so that the following
  // left shift produces a correct decimal carry into the next digit. All
  // digits are adjusted in parallel from the same pre-shift value.
  // --------------------------------------------------------------------------
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] digits);
    logic [BCD_W-1:0] res;
    res = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = digits[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = digits[4*k +: 4];
      end
    end
    return res;
  endfunction

  // State and datapath registers
  state_t             state_q,    state_d;
  logic [BIN_W-1:0]   sr_q,       sr_d;        // remaining binary bits, MSB first
  logic [BCD_W-1:0]   scr_q,      scr_d;       // scratch BCD digits
  logic               acc_q,      acc_d;       // overflow accumulator
  logic [CNT_W-1:0]   cnt_q,      cnt_d;       // iterations left
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [BCD_W-1:0]   bcd_q,      bcd_d;
  logic               overflow_q, overflow_d;

  // Combinational shift datapath
  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   scr_shift_s;
  logic [BIN_W-1:0]   sr_shift_s;
  logic               shift_out_s;

  // Adjust digits then shift {digits, binary} left by one; the bit leaving
  // the top digit is a decimal carry that the scratch cannot hold.
  always_comb begin
    adj_s = dabble_adjust(scr_q);
    {shift_out_s, scr_shift_s, sr_shift_s} = {adj_s, sr_q, 1'b0};
  end

  // Next-state and next-output logic for the conversion FSM
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    scr_d      = scr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = {BCD_W{1'b0}};
          acc_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        sr_d  = sr_shift_s;
        scr_d = scr_shift_s;
        acc_d = acc_q | shift_out_s;
        cnt_d = cnt_q - CNT_ONE;
        // The iteration that consumes the last binary bit ends the shift phase
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        bcd_d      = scr_q;
        overflow_d = acc_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        // Unreachable encoding: recover to idle without publishing a result
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= {BIN_W{1'b0}};
      scr_q      <= {BCD_W{1'b0}};
      acc_q      <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= {BCD_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      scr_q      <= scr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_bcd_seq
//
// Self-checking bench for bin_bcd_seq. Three instances share clk/rst_n:
//   u_d0: BIN_W=8,  DIGITS=3 (default)
//   u_d1: BIN_W=10, DIGITS=3 (overflow possible)
//   u_d2: BIN_W=16, DIGITS=5
// A reference model tracks acceptance/busy timing per instance and pushes
// the expected result (arithmetic div/mod reference) with its due cycle into
// a scoreboard queue; a monitor pops and compares on every done pulse and
// checks busy and the held bcd/overflow every cycle.
// ----------------------------------------------------------------------------
module tb_bin_bcd_seq;

  logic clk;
  logic rst_n;

  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        ovf_v   [3];
  logic [15:0] bin_v   [3];
  logic [19:0] bcd_v   [3];

  logic [7:0]  bin0;
  logic [9:0]  bin1;
  logic [15:0] bin2;
  logic [11:0] bcd0;
  logic [11:0] bcd1;
  logic [19:0] bcd2;

  typedef struct {
    logic [19:0] b;
    logic        o;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq [3][$];
  int unsigned cnt [3] = '{0, 0, 0};
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin(bin0),
    .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .overflow(ovf_v[0]));

  bin_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin(bin1),
    .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .overflow(ovf_v[1]));

  bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin(bin2),
    .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .overflow(ovf_v[2]));

  // Widen per-instance buses into uniform arrays for the model/monitor
  always_comb begin
    bin_v[0] = {8'd0, bin0};
    bin_v[1] = {6'd0, bin1};
    bin_v[2] = bin2;
    bcd_v[0] = {8'd0, bcd0};
    bcd_v[1] = {8'd0, bcd1};
    bcd_v[2] = bcd2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bw_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 10 : 16);
  endfunction

  function automatic int dg_of(input int i);
    return (i == 2) ? 5 : 3;
  endfunction

  function automatic logic [19:0] ref_bcd(input int unsigned v, input int d);
    logic [19:0] r;
    int unsigned t;
    r = 20'd0;
    t = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int d);
    int unsigned p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return (v >= p);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h exp 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: acceptance only when idle; busy spans BIN_W+1 edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= 0;
        sbq[i].delete();
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt[i] == 0) begin
          if (start_v[i] === 1'b1) begin
            sbq[i].push_back('{ref_bcd(32'(bin_v[i]), dg_of(i)),
                               ref_ovf(32'(bin_v[i]), dg_of(i)),
                               cyc + 32'(bw_of(i)) + 2});
            cnt[i] <= 32'(bw_of(i) + 1);
          end
        end else begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  // Monitor: compare outputs at the falling edge
  logic [19:0] held_b [3];
  logic        held_o [3];

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      held_b[i] = 20'd0;
      held_o[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          held_b[i] = 20'd0;
          held_o[i] = 1'b0;
          check_eq($sformatf("d%0d_rst_done", i), {31'd0, done_v[i]}, 32'd0);
        end else if (done_v[i] === 1'b1) begin
          if (sbq[i].size() == 0) begin
            check_eq($sformatf("d%0d_unexpected_done", i), 32'd1, 32'd0);
          end else begin
            e = sbq[i].pop_front();
            check_eq($sformatf("d%0d_latency", i), cyc, e.cyc);
            held_b[i] = e.b;
            held_o[i] = e.o;
          end
        end else if (sbq[i].size() != 0 && cyc > sbq[i][0].cyc) begin
          check_eq($sformatf("d%0d_missing_done", i), 32'd0, 32'd1);
          void'(sbq[i].pop_front());
        end
        check_eq($sformatf("d%0d_busy", i), {31'd0, busy_v[i]}, {31'd0, (cnt[i] != 0)});
        check_eq($sformatf("d%0d_bcd", i), {12'd0, bcd_v[i]}, {12'd0, held_b[i]});
        check_eq($sformatf("d%0d_ovf", i), {31'd0, ovf_v[i]}, {31'd0, held_o[i]});
      end
    end
  end

  task automatic set_bin(input int i, input logic [15:0] v);
    case (i)
      0:       bin0 = v[7:0];
      1:       bin1 = v[9:0];
      default: bin2 = v;
    endcase
  endtask

  // One-cycle start pulse with operand
  task automatic pulse(input int i, input logic [15:0] v);
    @(negedge clk);
    #2;
    start_v[i] = 1'b1;
    set_bin(i, v);
    @(negedge clk);
    #2;
    start_v[i] = 1'b0;
  endtask

  // Wait until the model says instance i is idle with no pending result
  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (cnt[i] == 0 && sbq[i].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("d%0d_idle_timeout", i), 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    bin0 = 8'd0;
    bin1 = 10'd0;
    bin2 = 16'd0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // 1. basic conversion
    pulse(0, 16'd145);
    wait_idle(0);

    // 2. bin=0 then bin=255, second start raised in the done cycle
    pulse(0, 16'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done_v[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t2_first_done_seen", {31'd0, seen}, 32'd1);
    start_v[0] = 1'b1;
    bin0 = 8'd255;
    @(negedge clk);
    #2;
    start_v[0] = 1'b0;
    wait_idle(0);

    // 3. start while busy is ignored
    pulse(0, 16'd145);
    repeat (2) @(negedge clk);
    pulse(0, 16'd17);
    wait_idle(0);

    // 4. asynchronous reset mid-conversion
    pulse(0, 16'd200);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t4_async_bcd", {20'd0, bcd0}, 32'd0);
    check_eq("t4_async_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("t4_async_done", {31'd0, done_v[0]}, 32'd0);
    check_eq("t4_async_ovf", {31'd0, ovf_v[0]}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    pulse(0, 16'd200);
    wait_idle(0);

    // 5. 10-bit operand into 3 digits: overflow and in-range
    pulse(1, 16'd1023);
    wait_idle(1);
    pulse(1, 16'd999);
    wait_idle(1);
    for (int k = 0; k < 20; k++) begin
      pulse(1, 16'($urandom_range(0, 1023)));
      wait_idle(1);
    end

    // 6. 16-bit operand into 5 digits
    pulse(2, 16'd65535);
    wait_idle(2);
    pulse(2, 16'd0);
    wait_idle(2);
    for (int k = 0; k < 10; k++) begin
      pulse(2, 16'($urandom_range(0, 65535)));
      wait_idle(2);
    end

    // start held high: back-to-back conversions with a changing operand
    @(negedge clk);
    #2;
    start_v[0] = 1'b1;
    for (int k = 0; k < 45; k++) begin
      bin0 = 8'($urandom_range(0, 255));
      @(negedge clk);
      #2;
    end
    start_v[0] = 1'b0;
    wait_idle(0);

    // exhaustive sweep at default parameters
    for (int v = 0; v < 256; v++) begin
      pulse(0, 16'(v));
      wait_idle(0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
